// File: rtl/element_cmd_sched.sv
// -----------------------------------------------------------------------------
// element_cmd_sched
// Timed command issuer for one element channel. Pulse commands are queued in a
// small FIFO; the head command is held until the element time counter reaches
// its trigger time and the element is idle, then its fields are driven to the
// element together with a one-cycle command strobe. Late issues are counted.
//
// Ports
//   clk, resetn          element clock, asynchronous active-low reset
//   cmd_in/valid/ready   128-bit command write handshake
//   flush                synchronous discard of queued and head commands
//   tcnt                 free-running element time counter (wraps)
//   elem_busy            element busy (prep/pulse/post or strobe)
//   cmdstb               one-cycle command strobe
//   envstart..mode       command fields, stable from the strobe until the next
//   fifo_count           queue occupancy (registered)
//   idle                 nothing queued, no head, not firing (registered)
//   late_cnt             saturating count of late issues
// -----------------------------------------------------------------------------
module element_cmd_sched #(
   parameter int unsigned ENV_ADDRWIDTH  = 12,
   parameter int unsigned FREQ_ADDRWIDTH = 9,
   parameter int unsigned TCNTWIDTH      = 27,
   parameter int unsigned FIFO_DEPTH     = 8
) (
   input  logic                            clk,
   input  logic                            resetn,
   input  logic [127:0]                    cmd_in,
   input  logic                            cmd_valid,
   output logic                            cmd_ready,
   input  logic                            flush,
   input  logic [TCNTWIDTH-1:0]            tcnt,
   input  logic                            elem_busy,
   output logic                            cmdstb,
   output logic [ENV_ADDRWIDTH-1:0]        envstart,
   output logic [ENV_ADDRWIDTH-1:0]        envlength,
   output logic [15:0]                     ampx,
   output logic [16:0]                     pini,
   output logic [FREQ_ADDRWIDTH-1:0]       freqaddr,
   output logic [1:0]                      mode,
   output logic [$clog2(FIFO_DEPTH):0]     fifo_count,
   output logic                            idle,
   output logic [15:0]                     late_cnt
);

   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam int unsigned CW = AW + 1;

   // Only the parameterised low bits of each field are kept in the queue.
   typedef struct packed {
      logic [1:0]                mode;
      logic [FREQ_ADDRWIDTH-1:0] freqaddr;
      logic [16:0]               pini;
      logic [15:0]               ampx;
      logic [ENV_ADDRWIDTH-1:0]  envlength;
      logic [ENV_ADDRWIDTH-1:0]  envstart;
      logic [TCNTWIDTH-1:0]      trigt;
   } cmd_t;

   typedef enum logic [1:0] {ST_EMPTY, ST_WAIT, ST_FIRE} state_t;

   state_t               state_q, state_d;
   cmd_t                 fifo_q [FIFO_DEPTH];
   cmd_t                 wr_entry;
   cmd_t                 head_q;
   logic [AW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]        count_q, count_d;
   logic                 rdy_en_q;
   logic                 idle_q, idle_d;
   logic [15:0]          late_cnt_q, late_cnt_d;
   logic [ENV_ADDRWIDTH-1:0]  envstart_q, envlength_q;
   logic [15:0]               ampx_q;
   logic [16:0]               pini_q;
   logic [FREQ_ADDRWIDTH-1:0] freqaddr_q;
   logic [1:0]                mode_q;

   logic                 push, pop, fire, go, fifo_empty, fifo_full;
   logic [TCNTWIDTH-1:0] diff;

   // Command bits above each field's width and [127:115] are ignored.
   logic unused_cmd_bits;
   assign unused_cmd_bits = ^cmd_in;

   assign wr_entry = '{mode:      cmd_in[114:113],
                       freqaddr:  cmd_in[97 +: FREQ_ADDRWIDTH],
                       pini:      cmd_in[96:80],
                       ampx:      cmd_in[79:64],
                       envlength: cmd_in[48 +: ENV_ADDRWIDTH],
                       envstart:  cmd_in[32 +: ENV_ADDRWIDTH],
                       trigt:     cmd_in[0 +: TCNTWIDTH]};

   assign fifo_empty = (count_q == '0);
   assign fifo_full  = (count_q == CW'(FIFO_DEPTH));
   // rdy_en_q holds ready low through reset and releases it one clock later.
   assign cmd_ready  = rdy_en_q & ~fifo_full & ~flush;
   assign push       = cmd_valid & cmd_ready;

   // Modular distance to the trigger; MSB set means the trigger is in the past.
   assign diff = head_q.trigt - tcnt;
   assign go   = ~elem_busy & ((diff == '0) | diff[TCNTWIDTH-1]);

   always_comb begin
      state_d = state_q;
      pop     = 1'b0;
      fire    = 1'b0;
      case (state_q)
         ST_EMPTY: begin
            if (!fifo_empty) begin
               pop     = 1'b1;
               state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (go) begin
               fire    = 1'b1;
               state_d = ST_FIRE;
            end
         end
         ST_FIRE: begin
            // elem_busy is not looked at here: it includes our own strobe.
            if (!fifo_empty) begin
               pop     = 1'b1;
               state_d = ST_WAIT;
            end else begin
               state_d = ST_EMPTY;
            end
         end
         default: state_d = ST_EMPTY;
      endcase
      if (flush) begin
         state_d = ST_EMPTY;
         pop     = 1'b0;
         fire    = 1'b0;
      end
   end

   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      late_cnt_d = late_cnt_q;
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (push && !pop)      count_d = count_q + 1'b1;
      else if (!push && pop) count_d = count_q - 1'b1;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end
      if (fire && (diff != '0) && (late_cnt_q != 16'hFFFF))
         late_cnt_d = late_cnt_q + 16'd1;
      idle_d = (count_d == '0) && (state_d == ST_EMPTY);
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q     <= ST_EMPTY;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         rdy_en_q    <= 1'b0;
         idle_q      <= 1'b1;
         late_cnt_q  <= '0;
         envstart_q  <= '0;
         envlength_q <= '0;
         ampx_q      <= '0;
         pini_q      <= '0;
         freqaddr_q  <= '0;
         mode_q      <= '0;
      end else begin
         state_q    <= state_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         rdy_en_q   <= 1'b1;
         idle_q     <= idle_d;
         late_cnt_q <= late_cnt_d;
         if (fire) begin
            envstart_q  <= head_q.envstart;
            envlength_q <= head_q.envlength;
            ampx_q      <= head_q.ampx;
            pini_q      <= head_q.pini;
            freqaddr_q  <= head_q.freqaddr;
            mode_q      <= head_q.mode;
         end
      end
   end

   // Queue storage and head register carry no reset; state gates their use.
   always_ff @(posedge clk) begin
      if (push) fifo_q[wr_ptr_q] <= wr_entry;
      if (pop)  head_q <= fifo_q[rd_ptr_q];
   end

   assign cmdstb     = (state_q == ST_FIRE);
   assign envstart   = envstart_q;
   assign envlength  = envlength_q;
   assign ampx       = ampx_q;
   assign pini       = pini_q;
   assign freqaddr   = freqaddr_q;
   assign mode       = mode_q;
   assign fifo_count = count_q;
   assign idle       = idle_q;
   assign late_cnt   = late_cnt_q;

endmodule

// File: tb/tb_element_cmd_sched.sv
// Directed bench for element_cmd_sched. tcnt advances by one right after every
// rising edge, so the value visible between edges is the one sampled next.
module tb_element_cmd_sched;

   logic          clk = 1'b0;
   logic          resetn;
   logic [127:0]  cmd_in;
   logic          cmd_valid;
   logic          cmd_ready;
   logic          flush;
   logic [26:0]   tcnt;
   logic          elem_busy;
   logic          cmdstb;
   logic [11:0]   envstart;
   logic [11:0]   envlength;
   logic [15:0]   ampx;
   logic [16:0]   pini;
   logic [8:0]    freqaddr;
   logic [1:0]    mode;
   logic [3:0]    fifo_count;
   logic          idle;
   logic [15:0]   late_cnt;

   int checks = 0;
   int errors = 0;

   // strobe log filled at the falling edge
   int          stb_cnt = 0;
   logic [26:0] stb_tcnt [64];
   logic [15:0] stb_amp  [64];

   element_cmd_sched dut (
      .clk(clk), .resetn(resetn), .cmd_in(cmd_in), .cmd_valid(cmd_valid),
      .cmd_ready(cmd_ready), .flush(flush), .tcnt(tcnt), .elem_busy(elem_busy),
      .cmdstb(cmdstb), .envstart(envstart), .envlength(envlength), .ampx(ampx),
      .pini(pini), .freqaddr(freqaddr), .mode(mode), .fifo_count(fifo_count),
      .idle(idle), .late_cnt(late_cnt)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (resetn === 1'b1 && cmdstb === 1'b1 && stb_cnt < 64) begin
         stb_tcnt[stb_cnt] <= tcnt;
         stb_amp[stb_cnt]  <= ampx;
         stb_cnt           <= stb_cnt + 1;
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      tcnt = tcnt + 27'd1;
   endtask

   task automatic push(input logic [127:0] w);
      cmd_in    = w;
      cmd_valid = 1'b1;
      step();
      cmd_valid = 1'b0;
   endtask

   function automatic logic [127:0] mk(input logic [31:0] t, input logic [15:0] es,
                                       input logic [15:0] el, input logic [15:0] ax,
                                       input logic [16:0] pi, input logic [15:0] fa,
                                       input logic [1:0] md);
      mk = {13'h0, md, fa, pi, ax, el, es, t};
   endfunction

   int          base;
   int          acc;
   logic        rdy_now;
   logic [26:0] t0;
   logic [26:0] span;

   initial begin
      resetn    = 1'b1;
      cmd_valid = 1'b0;
      cmd_in    = '0;
      flush     = 1'b0;
      elem_busy = 1'b0;
      tcnt      = '0;
      #2 resetn = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      // ---------------- reset state
      chk("rst_cmdstb", cmdstb, 0);
      chk("rst_envstart", envstart, 0);
      chk("rst_envlength", envlength, 0);
      chk("rst_ampx", ampx, 0);
      chk("rst_pini", pini, 0);
      chk("rst_freqaddr", freqaddr, 0);
      chk("rst_mode", mode, 0);
      chk("rst_fifo_count", fifo_count, 0);
      chk("rst_late_cnt", late_cnt, 0);
      chk("rst_idle", idle, 1);
      chk("rst_cmd_ready", cmd_ready, 0);
      resetn = 1'b1;
      #1;
      chk("ready_before_clk", cmd_ready, 0);
      step();
      chk("ready_after_clk", cmd_ready, 1);

      // ---------------- single on-time command
      tcnt = 27'd90;
      base = stb_cnt;
      push(mk(100, 16'h010, 16'h020, 16'h7fff, 17'h1234, 16'd5, 2'd0));
      chk("single_fifo_count", fifo_count, 1);
      chk("single_idle_busy", idle, 0);
      repeat (14) step();
      chk("single_stb_count", stb_cnt - base, 1);
      chk("single_stb_tcnt", stb_tcnt[base], 101);
      chk("single_envstart", envstart, 12'h010);
      chk("single_envlength", envlength, 12'h020);
      chk("single_ampx", ampx, 16'h7fff);
      chk("single_pini", pini, 17'h1234);
      chk("single_freqaddr", freqaddr, 5);
      chk("single_mode", mode, 0);
      chk("single_late", late_cnt, 0);
      chk("single_idle", idle, 1);

      // ---------------- busy at match: busy for tcnt 95..110
      tcnt = 27'd90;
      base = stb_cnt;
      push(mk(100, 16'h010, 16'h020, 16'h7fff, 17'h1234, 16'd5, 2'd0));
      for (int i = 0; i < 30; i++) begin
         elem_busy = (tcnt >= 27'd95 && tcnt <= 27'd110);
         step();
      end
      elem_busy = 1'b0;
      chk("busy_stb_count", stb_cnt - base, 1);
      chk("busy_stb_tcnt", stb_tcnt[base], 112);
      chk("busy_late", late_cnt, 1);

      // ---------------- trigger across counter wrap
      tcnt = 27'h7FFFFFD;
      base = stb_cnt;
      push(mk(1, 16'h0, 16'h0, 16'h1111, 17'h0, 16'd0, 2'd1));
      repeat (8) step();
      chk("wrap_stb_count", stb_cnt - base, 1);
      chk("wrap_stb_tcnt", stb_tcnt[base], 2);
      chk("wrap_ampx", ampx, 16'h1111);
      chk("wrap_mode", mode, 1);
      chk("wrap_late", late_cnt, 1);

      // ---------------- trigger already in the past
      tcnt = 27'd60;
      base = stb_cnt;
      push(mk(50, 16'h0, 16'h0, 16'h2222, 17'h0, 16'd0, 2'd0));
      repeat (4) step();
      chk("past_stb_count", stb_cnt - base, 1);
      chk("past_stb_tcnt", stb_tcnt[base], 63);
      chk("past_late", late_cnt, 2);

      // ---------------- fill queue while blocked, then release
      tcnt      = 27'd1000;
      elem_busy = 1'b1;
      base      = stb_cnt;
      acc       = 0;
      cmd_valid = 1'b1;
      for (int i = 0; i < 12; i++) begin
         cmd_in  = mk(0, 16'h0, 16'h0, 16'(acc + 1), 17'h0, 16'd0, 2'd0);
         rdy_now = cmd_ready;
         step();
         if (rdy_now) acc++;
      end
      cmd_valid = 1'b0;
      chk("full_accepted", acc, 9);
      chk("full_fifo_count", fifo_count, 8);
      chk("full_cmd_ready", cmd_ready, 0);
      chk("full_no_stb", stb_cnt - base, 0);
      elem_busy = 1'b0;
      repeat (24) step();
      chk("full_stb_count", stb_cnt - base, 9);
      for (int i = 0; i < 9; i++)
         chk($sformatf("full_order_%0d", i), stb_amp[base + i], i + 1);
      span = stb_tcnt[base + 8] - stb_tcnt[base];
      chk("full_spacing", span, 16);
      chk("full_fifo_drain", fifo_count, 0);
      chk("full_idle", idle, 1);
      chk("full_late", late_cnt, 11);

      // ---------------- flush with queued future commands
      tcnt = 27'd2000;
      base = stb_cnt;
      for (int i = 0; i < 3; i++)
         push(mk(3000, 16'h0, 16'h0, 16'(16'hA0 + i), 17'h0, 16'd0, 2'd0));
      cmd_in    = mk(2003, 16'h0, 16'h0, 16'hBAD0, 17'h0, 16'd0, 2'd0);
      cmd_valid = 1'b1;
      flush     = 1'b1;
      #1;
      chk("flush_ready_low", cmd_ready, 0);
      step();
      flush     = 1'b0;
      cmd_valid = 1'b0;
      chk("flush_fifo_count", fifo_count, 0);
      step();
      chk("flush_idle", idle, 1);
      repeat (1010) step();
      chk("flush_no_stb", stb_cnt - base, 0);
      chk("flush_ampx_kept", ampx, 9);
      chk("flush_late_kept", late_cnt, 11);

      // ---------------- normal command after flush
      base = stb_cnt;
      t0   = tcnt;
      push(mk(32'(t0 + 27'd10), 16'h0, 16'h0, 16'h5A5A, 17'h0, 16'd0, 2'd0));
      repeat (15) step();
      span = stb_tcnt[base] - t0;
      chk("post_stb_count", stb_cnt - base, 1);
      chk("post_stb_offset", span, 11);
      chk("post_ampx", ampx, 16'h5A5A);
      chk("post_late", late_cnt, 11);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
